// File: rtl/fcl_bn_sign.sv
// Folded batch-norm + sign over PAR accumulator lanes per beat, packed into OUT_BITS words.
// Word registered the cycle after its completing beat; in_ready drops only while a word is held unconsumed.
module fcl_bn_sign #(
   parameter int PAR        = 8,
   parameter int WIDTH      = 8,
   parameter int OUT_BITS   = 32,
   parameter int NEURON_MAX = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(NEURON_MAX):0]   cfg_neurons,
   input  logic                          thr_we,
   input  logic [$clog2(NEURON_MAX)-1:0] thr_addr,
   input  logic [WIDTH-1:0]              thr_data,
   input  logic                          thr_flip,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PAR*WIDTH-1:0]          in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_BITS-1:0]           out_word,
   output logic                          out_last
);

   localparam int AW = $clog2(NEURON_MAX);
   localparam int G  = OUT_BITS / PAR;
   localparam int CW = (G > 1) ? $clog2(G) : 1;

   logic signed [WIDTH-1:0] thr_q [NEURON_MAX];
   logic [NEURON_MAX-1:0]   flip_q;

   logic [AW-1:0]       nidx_q, nidx_d;
   logic [CW-1:0]       pack_cnt_q, pack_cnt_d;
   logic [OUT_BITS-1:0] pack_q, pack_d;
   logic [AW:0]         cfg_q;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [OUT_BITS-1:0] out_word_q, out_word_d;

   logic                accept;
   logic                layer_start;
   logic [AW:0]         layer_cfg;
   logic                layer_last;
   logic                word_done;
   logic [PAR-1:0]      beat_bits;
   logic [OUT_BITS-1:0] pack_new;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_word  = out_word_q;

   // Layer size is taken live on the first beat of a layer, then frozen in cfg_q.
   assign layer_start = (nidx_q == '0) && (pack_cnt_q == '0);
   assign layer_cfg   = layer_start ? cfg_neurons : cfg_q;
   assign layer_last  = (({1'b0, nidx_q} + (AW+1)'(PAR)) == layer_cfg);
   assign word_done   = (pack_cnt_q == CW'(G - 1)) || layer_last;

   always_comb begin
      beat_bits = '0;
      for (int j = 0; j < PAR; j++) begin
         beat_bits[j] = ($signed(in_data[j*WIDTH +: WIDTH]) >= thr_q[nidx_q + AW'(j)])
                        ^ flip_q[nidx_q + AW'(j)];
      end
   end

   always_comb begin
      pack_new = pack_q;
      pack_new[pack_cnt_q*PAR +: PAR] = beat_bits;
   end

   always_comb begin
      nidx_d      = nidx_q;
      pack_cnt_d  = pack_cnt_q;
      pack_d      = pack_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_word_d  = out_word_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      if (accept) begin
         if (word_done) begin
            out_word_d  = pack_new;
            out_valid_d = 1'b1;
            out_last_d  = layer_last;
            pack_d      = '0;
            pack_cnt_d  = '0;
            nidx_d      = layer_last ? '0 : nidx_q + AW'(PAR);
         end else begin
            pack_d      = pack_new;
            pack_cnt_d  = pack_cnt_q + 1'b1;
            nidx_d      = nidx_q + AW'(PAR);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nidx_q      <= '0;
         pack_cnt_q  <= '0;
         pack_q      <= '0;
         cfg_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_word_q  <= '0;
      end else begin
         nidx_q      <= nidx_d;
         pack_cnt_q  <= pack_cnt_d;
         pack_q      <= pack_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_word_q  <= out_word_d;
         if (layer_start) cfg_q <= cfg_neurons;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NEURON_MAX; i++) thr_q[i] <= '0;
         flip_q <= '0;
      end else if (thr_we) begin
         thr_q[thr_addr]  <= $signed(thr_data);
         flip_q[thr_addr] <= thr_flip;
      end
   end

endmodule

// File: tb/tb_fcl_bn_sign.sv
// Bench for fcl_bn_sign: directed scenarios plus randomized layers against a neuron-level model.
module tb_fcl_bn_sign;
   localparam int PAR = 8, WIDTH = 8, OUT_BITS = 32, NEURON_MAX = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [8:0]  cfg_neurons = '0;
   logic        thr_we = 1'b0;
   logic [7:0]  thr_addr = '0;
   logic [7:0]  thr_data = '0;
   logic        thr_flip = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_word;
   logic        out_last;

   always #5 clk = ~clk;

   fcl_bn_sign #(.PAR(PAR), .WIDTH(WIDTH), .OUT_BITS(OUT_BITS), .NEURON_MAX(NEURON_MAX)) dut (
      .clk(clk), .rst(rst), .cfg_neurons(cfg_neurons),
      .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data), .thr_flip(thr_flip),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last)
   );

   typedef struct { logic [31:0] word; logic last; } exp_t;
   exp_t exp_q[$];
   int   thr_m [NEURON_MAX];
   bit   flip_m[NEURON_MAX];
   bit   act   [NEURON_MAX];
   int   m_nidx, m_wstart, m_cfg;
   int   n_checks = 0, n_err = 0;
   bit   s_acc, s_in_ready;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_nidx = 0; m_wstart = 0; m_cfg = 0;
      for (int i = 0; i < NEURON_MAX; i++) begin thr_m[i] = 0; flip_m[i] = 0; end
   endtask

   // Activation per neuron, then words cut every OUT_BITS neurons or at layer end.
   task automatic model_beat(input logic [63:0] d);
      logic [31:0] w;
      int lane;
      bit last;
      if (m_nidx == 0) m_cfg = int'(cfg_neurons);
      for (int j = 0; j < PAR; j++) begin
         lane = int'($signed(d[j*WIDTH +: WIDTH]));
         act[m_nidx + j] = (lane >= thr_m[m_nidx + j]) ^ flip_m[m_nidx + j];
      end
      m_nidx += PAR;
      if ((m_nidx - m_wstart == OUT_BITS) || (m_nidx == m_cfg)) begin
         w = '0;
         for (int k = 0; k < m_nidx - m_wstart; k++) w[k] = act[m_wstart + k];
         last = (m_nidx == m_cfg);
         exp_q.push_back('{word: w, last: last});
         if (last) m_nidx = 0;
         m_wstart = m_nidx;
      end
   endtask

   task automatic step();
      @(negedge clk);
      s_acc = 1'b0;
      if (rst) begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         chk("out_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("out_word", out_word, exp_q[0].word);
            chk("out_last", out_last, exp_q[0].last);
         end
         if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) begin model_beat(in_data); s_acc = 1'b1; end
         if (thr_we) begin
            thr_m[thr_addr]  = int'($signed(thr_data));
            flip_m[thr_addr] = thr_flip;
         end
      end
      s_in_ready = in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input string tag, input logic [31:0] w, input logic l);
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_word"}, out_word, w);
      chk({tag, "_last"}, out_last, l);
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [63:0] d);
      in_valid = 1'b1;
      in_data  = d;
      s_acc    = 1'b0;
      for (int k = 0; k < 50 && !s_acc; k++) step();
      if (!s_acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
      chk("drain_left", exp_q.size(), 0);
      step();
   endtask

   task automatic wr_thr(input int a, input int v, input bit f);
      thr_we   = 1'b1;
      thr_addr = a[7:0];
      thr_data = v[7:0];
      thr_flip = f;
      step();
      thr_we   = 1'b0;
   endtask

   function automatic logic [63:0] alt(input int a, input int b);
      logic [63:0] d;
      int v;
      for (int j = 0; j < PAR; j++) begin
         v = (j % 2 == 0) ? a : b;
         d[j*8 +: 8] = v[7:0];
      end
      return d;
   endfunction

   function automatic logic [63:0] rnd_beat(input int base);
      logic [63:0] d;
      int v;
      for (int j = 0; j < PAR; j++) begin
         if ($urandom_range(3) == 0) v = thr_m[base + j] + int'($urandom_range(2)) - 1;
         else v = int'($urandom_range(255));
         d[j*8 +: 8] = v[7:0];
      end
      return d;
   endfunction

   task automatic run_layer(input int cfg_v, input int p_valid, input int p_ready);
      int beats, sent, guard;
      beats = cfg_v / PAR; sent = 0; guard = 0;
      cfg_neurons = cfg_v[8:0];
      in_valid = 1'b0;
      while (sent < beats && guard < 5000) begin
         if (!in_valid && int'($urandom_range(99)) < p_valid) begin
            in_valid = 1'b1;
            in_data  = rnd_beat(m_nidx);
         end
         out_ready = int'($urandom_range(99)) < p_ready;
         if (m_nidx != 0) cfg_neurons = 9'($urandom_range(32) * 8);
         step();
         guard++;
         if (s_acc) begin sent++; in_valid = 1'b0; end
      end
      chk("layer_beats", sent, beats);
      drain();
   endtask

   initial begin
      logic [63:0] d;
      int v;
      int t2v[8];
      int cfg_v;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_word", out_word, 32'h0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst = 1'b1;
      step();

      // T1: alternating +5/-5 against zero thresholds
      cfg_neurons = 9'd32;
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) send_beat(alt(5, -5));
      peek("t1", 32'h5555_5555, 1'b1);
      drain();

      // T2: threshold equality, extremes and a flipped neuron
      for (int i = 0; i < 8; i++) wr_thr(i, 10, i == 2);
      t2v = '{10, 9, 127, -128, 0, 0, 0, 0};
      for (int j = 0; j < 8; j++) begin v = t2v[j]; d[j*8 +: 8] = v[7:0]; end
      cfg_neurons = 9'd8;
      out_ready = 1'b0;
      send_beat(d);
      peek("t2", 32'h0000_0001, 1'b1);
      drain();

      // T3/T4: 40-neuron layer with a stalled consumer on the full word
      for (int i = 0; i < 8; i++) wr_thr(i, 0, 1'b0);
      cfg_neurons = 9'd40;
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) send_beat(alt(1, 1));
      peek("t3_w0", 32'hFFFF_FFFF, 1'b0);
      in_valid = 1'b1;
      in_data  = alt(1, 1);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("t4_in_ready", s_in_ready, 1'b0);
         chk("t4_no_accept", s_acc, 1'b0);
      end
      out_ready = 1'b1;
      step();
      chk("t4_accept", s_acc, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      peek("t3_w1", 32'h0000_00FF, 1'b1);
      drain();

      // T5: reset mid-layer clears partial word and thresholds
      for (int i = 0; i < 8; i++) wr_thr(i, -5, 1'b0);
      cfg_neurons = 9'd32;
      out_ready = 1'b1;
      send_beat(rnd_beat(0));
      send_beat(rnd_beat(8));
      rst = 1'b0;
      model_reset();
      #1;
      chk("t5_valid", out_valid, 1'b0);
      chk("t5_word", out_word, 32'h0);
      chk("t5_last", out_last, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cfg_neurons = 9'd8;
      out_ready = 1'b0;
      send_beat({{7{8'hFF}}, 8'h00});
      peek("t5_restart", 32'h0000_0001, 1'b1);
      drain();

      // T6: continuous streaming, 64 neurons
      cfg_neurons = 9'd64;
      out_ready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         in_valid = 1'b1;
         in_data  = rnd_beat(m_nidx);
         step();
         chk("t6_in_ready", s_in_ready, 1'b1);
         chk("t6_accept", s_acc, 1'b1);
      end
      drain();

      // Randomized layers with fresh thresholds loaded between layers
      for (int l = 0; l < 40; l++) begin
         for (int w = 0; w < 24; w++)
            wr_thr(int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom_range(1)));
         cfg_v = int'($urandom_range(1, 32)) * 8;
         if (l % 5 == 4) run_layer(cfg_v, 100, 100);
         else run_layer(cfg_v, 60, 60);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
